// File: rtl/scv_patch_pkg.sv
// scv_patch_pkg: channel-state enum, register-select enum and select-width helper.
// The register-select encoding (A=0 .. V=7) is also what the upd7800 patch port decodes.
package scv_patch_pkg;
  typedef enum logic [2:0] {CH_IDLE, CH_WAIT, CH_ARMED, CH_PEND, CH_DONE} chan_state_t;
  typedef enum logic [2:0] {PR_A, PR_B, PR_C, PR_D, PR_E, PR_H, PR_L, PR_V} patch_reg_t;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scv_boot_patch_if.sv
// scv_boot_patch_if: config, CPU fetch-watch and patch-write signals of scv_boot_patch.
// master: the scv/CPU side (drives EN, CFG_*, CPU_*; receives PATCH_*, FIRED, BUSY).
// slave:  the patch engine.
interface scv_boot_patch_if import scv_patch_pkg::*; #(
  parameter int NCH = 4,
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int TW = 24
);
  localparam int SW = sel_w(NCH);
  logic EN;
  logic CFG_WE;
  logic [SW-1:0] CFG_SEL;
  logic [AW-1:0] CFG_PC;
  patch_reg_t CFG_REG;
  logic [DW-1:0] CFG_VAL;
  logic [TW-1:0] CFG_DELAY;
  logic CPU_CE;
  logic CPU_FETCH;
  logic [AW-1:0] CPU_PC;
  logic PATCH_WE;
  patch_reg_t PATCH_REG;
  logic [DW-1:0] PATCH_VAL;
  logic [NCH-1:0] FIRED;
  logic BUSY;
  modport master (
    output EN, CFG_WE, CFG_SEL, CFG_PC, CFG_REG, CFG_VAL, CFG_DELAY, CPU_CE, CPU_FETCH, CPU_PC,
    input PATCH_WE, PATCH_REG, PATCH_VAL, FIRED, BUSY
  );
  modport slave (
    input EN, CFG_WE, CFG_SEL, CFG_PC, CFG_REG, CFG_VAL, CFG_DELAY, CPU_CE, CPU_FETCH, CPU_PC,
    output PATCH_WE, PATCH_REG, PATCH_VAL, FIRED, BUSY
  );
endinterface

// File: rtl/scv_patch_chan.sv
// scv_patch_chan: one watch-and-patch channel (state, arm-delay counter, PC compare, stored REG/VAL).
// Ports: clk, rst (sync, active-high); en global enable; load = this channel's config write;
// grant from the top arbiter; cpu_ce/cpu_fetch/cpu_pc fetch watch;
// pend/busy/fired status; rg/val the stored write payload.
module scv_patch_chan import scv_patch_pkg::*; #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int TW = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic [AW-1:0] cfg_pc,
  input  patch_reg_t cfg_reg,
  input  logic [DW-1:0] cfg_val,
  input  logic [TW-1:0] cfg_delay,
  input  logic cpu_ce,
  input  logic cpu_fetch,
  input  logic [AW-1:0] cpu_pc,
  input  logic grant,
  output logic pend,
  output logic busy,
  output logic fired,
  output patch_reg_t rg,
  output logic [DW-1:0] val
);
  chan_state_t state, state_n;
  logic [TW-1:0] cnt;
  logic [AW-1:0] pc;
  logic hit;
  assign hit = en && cpu_ce && cpu_fetch && cpu_pc == pc;
  // Leaving WAIT when the counter shows 1 makes a delay D loaded in cycle L arm at L+D+1.
  always_comb
    state_n = load ? (cfg_delay == '0 ? CH_ARMED : CH_WAIT) :
              (state == CH_WAIT && en && cnt == TW'(1)) ? CH_ARMED :
              (state == CH_ARMED && hit) ? CH_PEND :
              (state == CH_PEND && grant) ? CH_DONE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_IDLE;
      cnt <= '0;
      pc <= '0;
      rg <= PR_A;
      val <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        cnt <= cfg_delay;
        pc <= cfg_pc;
        rg <= cfg_reg;
        val <= cfg_val;
      end else if (state == CH_WAIT && en) begin
        cnt <= cnt - TW'(1);
      end
    end
  end
  assign pend = state == CH_PEND;
  assign busy = state inside {CH_WAIT, CH_ARMED, CH_PEND};
  assign fired = state == CH_DONE;
endmodule

// File: rtl/scv_boot_patch.sv
// scv_boot_patch: multi-channel PC watch-and-patch engine emitting one register-write strobe per match.
// Ports: CLK system clock; RES sync active-high reset; bus (scv_boot_patch_if.slave) carrying
// EN, CFG_* channel load, CPU_* fetch watch, PATCH_* write strobe, FIRED flags and BUSY.
module scv_boot_patch import scv_patch_pkg::*; #(
  parameter int NCH = 4,
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int TW = 24
) (
  input logic CLK,
  input logic RES,
  scv_boot_patch_if.slave bus
);
  logic [NCH-1:0] load, pend, busy, fired, elig, grant;
  patch_reg_t rg [NCH];
  logic [DW-1:0] val [NCH];
  patch_reg_t sel_reg, last_reg;
  logic [DW-1:0] sel_val, last_val;
  logic we;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load[i] = bus.CFG_WE && int'(bus.CFG_SEL) == i;
    scv_patch_chan #(.AW(AW), .DW(DW), .TW(TW)) u_chan (
      .clk(CLK),
      .rst(RES),
      .en(bus.EN),
      .load(load[i]),
      .cfg_pc(bus.CFG_PC),
      .cfg_reg(bus.CFG_REG),
      .cfg_val(bus.CFG_VAL),
      .cfg_delay(bus.CFG_DELAY),
      .cpu_ce(bus.CPU_CE),
      .cpu_fetch(bus.CPU_FETCH),
      .cpu_pc(bus.CPU_PC),
      .grant(grant[i]),
      .pend(pend[i]),
      .busy(busy[i]),
      .fired(fired[i]),
      .rg(rg[i]),
      .val(val[i])
    );
  end
  // A channel being reloaded this cycle loses its pending write; reset cancels any strobe.
  assign elig = RES ? '0 : pend & ~load;
  // Isolate the lowest set bit: lowest channel index wins.
  assign grant = elig & (~elig + NCH'(1));
  assign we = |grant;
  always_comb begin
    sel_reg = PR_A;
    sel_val = '0;
    for (int k = 0; k < NCH; k++)
      if (grant[k]) begin
        sel_reg = rg[k];
        sel_val = val[k];
      end
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      last_reg <= PR_A;
      last_val <= '0;
    end else if (we) begin
      last_reg <= sel_reg;
      last_val <= sel_val;
    end
  end
  assign bus.PATCH_WE = we;
  assign bus.PATCH_REG = we ? sel_reg : last_reg;
  assign bus.PATCH_VAL = we ? sel_val : last_val;
  assign bus.FIRED = fired;
  assign bus.BUSY = |busy;
endmodule

// File: tb/tb_scv_boot_patch.sv
// tb_scv_boot_patch: directed table-driven bench for scv_boot_patch plus delay, reload and reset sequences.
module tb_scv_boot_patch;
  import scv_patch_pkg::*;
  logic CLK = 1'b0;
  logic RES = 1'b1;
  always #5 CLK = ~CLK;
  scv_boot_patch_if #(.NCH(4), .AW(16), .DW(8), .TW(24)) bus ();
  scv_boot_patch #(.NCH(4), .AW(16), .DW(8), .TW(24)) dut (.CLK(CLK), .RES(RES), .bus(bus));
  typedef struct {
    logic we; int sel; logic [15:0] pc; patch_reg_t rg; logic [7:0] val; logic [23:0] dly;
    logic en; logic ce; logic fetch; logic [15:0] cpu_pc;
    int x_we; int x_reg; int x_val; int x_fired; int x_busy;
  } vec_t;
  vec_t tv [20];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input int sel, input logic [15:0] pc, input patch_reg_t rg,
                       input logic [7:0] val, input logic [23:0] dly, input logic en, input logic ce,
                       input logic fetch, input logic [15:0] cpu_pc);
    bus.CFG_WE = we;
    bus.CFG_SEL = 2'(sel);
    bus.CFG_PC = pc;
    bus.CFG_REG = rg;
    bus.CFG_VAL = val;
    bus.CFG_DELAY = dly;
    bus.EN = en;
    bus.CPU_CE = ce;
    bus.CPU_FETCH = fetch;
    bus.CPU_PC = cpu_pc;
  endtask
  task automatic idle();
    drive(1'b0, 0, 16'h0, PR_A, 8'h0, 24'h0, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask
  task automatic fetch(input logic [15:0] a);
    drive(1'b0, 0, 16'h0, PR_A, 8'h0, 24'h0, 1'b1, 1'b1, 1'b1, a);
  endtask
  task automatic next();
    @(posedge CLK);
    #1;
  endtask
  task automatic outs(input string tag, input int xwe, input int xreg, input int xval, input int xfired, input int xbusy);
    chk({tag, " PATCH_WE"}, int'(bus.PATCH_WE), xwe);
    chk({tag, " PATCH_REG"}, int'(bus.PATCH_REG), xreg);
    chk({tag, " PATCH_VAL"}, int'(bus.PATCH_VAL), xval);
    chk({tag, " FIRED"}, int'(bus.FIRED), xfired);
    chk({tag, " BUSY"}, int'(bus.BUSY), xbusy);
  endtask
  initial begin
    tv[0]  = '{1, 0, 'h0016, PR_C, 'h01, 0, 1, 1, 0, 'h0000, 0, 0, 'h00, 'h0, 0};
    tv[1]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 1, 'h0016, 0, 0, 'h00, 'h0, 1};
    tv[2]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 1, 2, 'h01, 'h0, 1};
    tv[3]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h1, 0};
    tv[4]  = '{1, 1, 'h0018, PR_B, 'h00, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h1, 0};
    tv[5]  = '{1, 2, 'h0018, PR_C, 'h01, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h1, 1};
    tv[6]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 1, 'h0019, 0, 2, 'h01, 'h1, 1};
    tv[7]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 1, 'h0018, 0, 2, 'h01, 'h1, 1};
    tv[8]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 1, 1, 'h00, 'h1, 1};
    tv[9]  = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 1, 2, 'h01, 'h3, 1};
    tv[10] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h7, 0};
    tv[11] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 1, 'h0018, 0, 2, 'h01, 'h7, 0};
    tv[12] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h7, 0};
    tv[13] = '{1, 3, 'h0020, PR_H, 'h5A, 0, 1, 1, 0, 'h0000, 0, 2, 'h01, 'h7, 0};
    tv[14] = '{0, 0, 'h0000, PR_A, 'h00, 0, 0, 1, 1, 'h0020, 0, 2, 'h01, 'h7, 1};
    tv[15] = '{0, 0, 'h0000, PR_A, 'h00, 0, 0, 1, 0, 'h0000, 0, 2, 'h01, 'h7, 1};
    tv[16] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 0, 1, 'h0020, 0, 2, 'h01, 'h7, 1};
    tv[17] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 1, 'h0020, 0, 2, 'h01, 'h7, 1};
    tv[18] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 1, 5, 'h5A, 'h7, 1};
    tv[19] = '{0, 0, 'h0000, PR_A, 'h00, 0, 1, 1, 0, 'h0000, 0, 5, 'h5A, 'hF, 0};
    idle();
    RES = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RES = 1'b0;
    @(negedge CLK);
    outs("reset", 0, 0, 0, 0, 0);
    next();
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].we, tv[i].sel, tv[i].pc, tv[i].rg, tv[i].val, tv[i].dly, tv[i].en, tv[i].ce, tv[i].fetch, tv[i].cpu_pc);
      @(negedge CLK);
      outs($sformatf("vec%0d", i), tv[i].x_we, tv[i].x_reg, tv[i].x_val, tv[i].x_fired, tv[i].x_busy);
      next();
    end
    // ch0 reload with delay 100 at cycle L: fetches at L+50 and L+100 miss, L+101 hits.
    drive(1'b1, 0, 16'h0016, PR_C, 8'h01, 24'd100, 1'b1, 1'b1, 1'b0, 16'h0);
    next();
    for (int k = 1; k <= 101; k++) begin
      drive(1'b0, 0, 16'h0, PR_A, 8'h0, 24'h0, 1'b1, 1'b1, k == 50 || k == 100 || k == 101, 16'h0016);
      @(negedge CLK);
      if (k == 1) chk("dly FIRED cleared", int'(bus.FIRED), 'hE);
      chk($sformatf("dly c%0d PATCH_WE", k), int'(bus.PATCH_WE), 0);
      chk($sformatf("dly c%0d BUSY", k), int'(bus.BUSY), 1);
      next();
    end
    idle();
    @(negedge CLK);
    outs("dly strobe", 1, 2, 'h01, 'hE, 1);
    next();
    @(negedge CLK);
    outs("dly done", 0, 2, 'h01, 'hF, 0);
    next();
    // Reload ch1 in the very cycle it would be granted.
    drive(1'b1, 1, 16'h0040, PR_B, 8'h33, 24'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    next();
    fetch(16'h0040);
    next();
    drive(1'b1, 1, 16'h0040, PR_B, 8'h33, 24'd5, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge CLK);
    chk("reload PATCH_WE", int'(bus.PATCH_WE), 0);
    chk("reload PATCH_REG", int'(bus.PATCH_REG), 2);
    next();
    idle();
    @(negedge CLK);
    outs("reload after", 0, 2, 'h01, 'hD, 1);
    next();
    // Reset while ch3 is PEND.
    drive(1'b1, 3, 16'h0030, PR_V, 8'hA5, 24'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    next();
    fetch(16'h0030);
    next();
    idle();
    RES = 1'b1;
    next();
    RES = 1'b0;
    @(negedge CLK);
    outs("post-reset", 0, 0, 0, 0, 0);
    next();
    fetch(16'h0030);
    next();
    idle();
    @(negedge CLK);
    outs("post-reset fetch", 0, 0, 0, 0, 0);
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scv_boot_patch.md
# scv_boot_patch

Synthesizable, parametrised successor to the bench-side boot shortcut: a multi-channel watch-and-patch engine that monitors the uPD7800 instruction-fetch PC and, when an armed channel matches, emits a single register-write strobe into the CPU's register file. It sits beside `upd7800` inside `scv`, letting simulation and FPGA builds skip long delay loops (e.g. the boot loops at PC 0x0016/0x0018) without hierarchical pokes. With `EN` low it is inert.

## Interface
- `NCH`, default 4: number of patch channels (1..16).
- `AW`, default 16: PC width.
- `DW`, default 8: patch value width.
- `TW`, default 24: arm-delay counter width.
- `CLK`  in  1  system clock (28.636 MHz domain of `scv`).
- `RES`  in  1  reset, synchronous, active-high; one clock, `CLK`.
- `EN`  in  1  global enable; low blocks arming/matching, pending writes still drain.
- `CFG_WE`  in  1  load channel `CFG_SEL` this cycle.
- `CFG_SEL`  in  $clog2(NCH)  channel index (out-of-range ignored).
- `CFG_PC`  in  AW  match address.
- `CFG_REG`  in  3  target register (A,B,C,D,E,H,L,V).
- `CFG_VAL`  in  DW  value written.
- `CFG_DELAY`  in  TW  CLK cycles after load before arming.
- `CPU_CE`  in  1  CPU clock enable.
- `CPU_FETCH`  in  1  opcode fetch in progress (qualified by `CPU_CE`).
- `CPU_PC`  in  AW  fetch address.
- `PATCH_WE`  out  1  one-cycle write strobe to CPU.
- `PATCH_REG`  out  3  register select.
- `PATCH_VAL`  out  DW  value.
- `FIRED`  out  NCH  sticky per-channel done flags.
- `BUSY`  out  1  any channel in WAIT, ARMED or PEND.

## Operation
- Per-channel states: IDLE -> (CFG_WE) WAIT -> (delay counter reaches 0) ARMED -> (match) PEND -> (granted) DONE. DONE and IDLE are stable until reloaded.
- WAIT: counter loaded with `CFG_DELAY`, decrements every CLK while `EN`; `CFG_DELAY`=0 goes straight to ARMED next cycle.
- ARMED: match when `EN && CPU_CE && CPU_FETCH && CPU_PC==CFG_PC`. Each channel fires exactly once.
- Arbiter: among PEND channels, lowest index wins; one grant per cycle; losers stay PEND.
- Several channels may share a PC (e.g. B=0 and C=1 at 0x0018); they serialize in index order on consecutive cycles.
- `CFG_WE` to a channel in any state reloads it and enters WAIT, clearing its `FIRED` bit and any pending write; if that channel is granted the same cycle, config wins and no strobe is issued.
- `EN` low: WAIT counters freeze, ARMED never matches, PEND channels still drain.

## Timing
- Reset: all channels IDLE, counters 0, `PATCH_WE`=0, `PATCH_REG`=0, `PATCH_VAL`=0, `FIRED`=0, `BUSY`=0. Reset mid-write cancels pending writes.
- Match registered in cycle N (state -> PEND at N+1); `PATCH_WE` high in N+1 if granted; DONE/`FIRED` set at N+2.
- `PATCH_WE` lasts exactly one CLK; `PATCH_REG`/`PATCH_VAL` valid only while high (held at last values otherwise).
- CPU must sample the strobe on any CLK, independent of `CPU_CE`.
- Delay D loaded at cycle L: ARMED from cycle L+D+1.

## Structure
- Package `scv_patch_pkg`: channel state enum (IDLE, WAIT, ARMED, PEND, DONE), register-select enum `patch_reg_t` (A=0,B,C,D,E,H,L,V=7), shared between this block and `upd7800` patch port.
- Sub-module `scv_patch_chan` (one channel: state, delay counter, compare, stored PC/REG/VAL), instantiated `NCH` times; top holds priority arbiter and output registers.

## Test plan
- Reset then load ch0 {PC=0x0016, REG=C, VAL=1, DELAY=0}; drive fetch at 0x0016 -> one `PATCH_WE` with REG=2, VAL=0x01 next cycle, `FIRED`=0001, `BUSY`=0.
- Load ch1 {0x0018,B,0x00} and ch2 {0x0018,C,0x01}; single fetch at 0x0018 -> strobes B/0x00 then C/0x01 on consecutive cycles, `FIRED`=0110.
- ch0 DELAY=100, fetch 0x0016 at cycle 50 and 150 -> no strobe at 50, strobe after 150.
- Repeated fetches at matching PC after DONE -> no further strobes.
- `EN`=0 with ARMED channel and matching fetch -> no strobe; `EN`=1 and fetch again -> strobe.
- Reload ch1 in same cycle it would be granted -> no strobe, ch1 in WAIT, `FIRED[1]`=0; `RES` while PEND -> all outputs 0 next cycle.
